// File: rtl/lsu_pkg.sv
// Shared codes for the load/store unit: funct3 widths, FSM states, fault codes.
// No logic with latency; the fault classifier is purely combinational.
// No flow control here; used by the control FSM, the extender and the bench.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_ILLEGAL  = 2'd2,
        FLT_TIMEOUT  = 2'd3
    } lsu_fault_e;

    // Classify a request before it reaches memory; an illegal width code
    // outranks a misaligned address.
    function automatic lsu_fault_e lsu_check(input logic       write,
                                             input logic [2:0] funct3,
                                             input logic [1:0] lane);
        logic illegal;
        logic misal;
        illegal = 1'b0;
        misal   = 1'b0;
        case (funct3)
            F3_B:    misal = 1'b0;
            F3_H:    misal = lane[0];
            F3_W:    misal = |lane;
            F3_BU:   illegal = write;
            F3_HU: begin
                illegal = write;
                misal   = lane[0];
            end
            default: illegal = 1'b1;
        endcase
        return illegal ? FLT_ILLEGAL : (misal ? FLT_MISALIGN : FLT_NONE);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a little-endian word and extends it.
// Combinational, zero latency.
// No backpressure; output follows inputs.
module load_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      lane_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by sign or zero extension by width code
    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
        data_o   = '0;
        case (funct3_i)
            F3_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access unit: one load/store per handshake, faults instead of bad accesses.
// Latency: 2 edges accept->response with zero-wait ack, +1 per wait cycle; faults respond next cycle.
// Backpressure: req_ready only in IDLE; memory stalls via mem_ack, bounded by ACK_TIMEOUT.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic [1:0]      resp_fault,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int             CW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    lsu_state_e      state_q;
    lsu_fault_e      fault_q;
    lsu_fault_e      req_flt;
    logic            wr_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [3:0]      wstrb_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      st_strb_d;
    logic [XLEN-1:0] st_wdata_d;
    logic [XLEN-1:0] ld_data;

    assign req_flt = lsu_check(req_write, req_funct3, req_addr[1:0]);

    // Store lane steering computed from the incoming request, latched on accept
    always_comb begin
        st_strb_d  = 4'b0000;
        st_wdata_d = '0;
        case (req_funct3)
            F3_B: begin
                st_strb_d  = 4'b0001 << req_addr[1:0];
                st_wdata_d = XLEN'(req_wdata[7:0]) << {req_addr[1:0], 3'b000};
            end
            F3_H: begin
                st_strb_d  = 4'b0011 << {req_addr[1], 1'b0};
                st_wdata_d = XLEN'(req_wdata[15:0]) << {req_addr[1], 4'b0000};
            end
            F3_W: begin
                st_strb_d  = 4'b1111;
                st_wdata_d = req_wdata;
            end
            default: begin
                st_strb_d  = 4'b0000;
                st_wdata_d = '0;
            end
        endcase
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3_i (f3_q),
        .lane_i   (addr_q[1:0]),
        .word_i   (mem_rdata),
        .data_o   (ld_data)
    );

    // Control FSM: latch request, run the memory access with a timeout, then pulse a response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fault_q <= FLT_NONE;
            wr_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wstrb_q <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wstrb_q <= st_strb_d;
                        wdata_q <= st_wdata_d;
                        cnt_q   <= '0;
                        if (req_flt != FLT_NONE) begin
                            fault_q <= req_flt;
                            rdata_q <= '0;
                            state_q <= ST_RESPOND;
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    // An ack on the expiry edge still completes the access cleanly
                    if (mem_ack) begin
                        fault_q <= FLT_NONE;
                        rdata_q <= wr_q ? '0 : ld_data;
                        state_q <= ST_RESPOND;
                    end else if ((ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                        fault_q <= FLT_TIMEOUT;
                        rdata_q <= '0;
                        state_q <= ST_RESPOND;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RESPOND: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode directly from registered state, so reset clears them at once
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESPOND);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
    assign mem_req    = (state_q == ST_ACCESS);
    assign mem_we     = mem_req & wr_q;
    assign mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wstrb  = mem_we ? wstrb_q : 4'b0000;
    assign mem_wdata  = mem_we ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a two-word memory with programmable ack delay.
// Each request checks latency, memory port values, response data and fault code.
// Responder acks after ack_delay wait cycles; ack_delay < 0 never acks.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_chk = 0;
    int n_bad = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    bit stray_ack = 1'b0;

    load_store_unit #(.XLEN(32), .ACK_TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_00a0: return 32'h4433_2211;
            32'h0000_00a8: return 32'hc7d6_e5f4;
            default:       return 32'hdead_beef;
        endcase
    endfunction

    // Memory responder: updates ack/data on the falling edge
    initial forever begin
        @(negedge clk);
        if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hffff_ffff;
        end else if (mem_req && ack_delay >= 0 && wait_cnt == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(mem_addr);
            wait_cnt  = 0;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            wait_cnt  = mem_req ? wait_cnt + 1 : 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request: e_lat = cycles from accept edge (+1) until resp_valid is seen
    task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input int dly,
                           input logic [1:0] e_flt, input logic [31:0] e_rd, input int e_lat,
                           input logic [31:0] e_madr, input logic [3:0] e_strb,
                           input logic [31:0] e_wd);
        int          lat;
        int          req_cyc;
        logic [31:0] s_madr;
        logic [3:0]  s_strb;
        logic [31:0] s_wd;
        logic        s_we;
        logic        busy_rdy;
        logic        e_mem;
        e_mem = (e_flt == 2'd0) || (e_flt == 2'd3);
        @(negedge clk);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        ack_delay  = dly;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0; req_cyc = 0; busy_rdy = 1'b0;
        s_madr = '0; s_strb = '0; s_wd = '0; s_we = 1'b0;
        while (!resp_valid && lat < 40) begin
            if (req_ready) busy_rdy = 1'b1;
            if (mem_req) begin
                req_cyc++;
                s_madr = mem_addr;
                s_strb = mem_wstrb;
                s_wd   = mem_wdata;
                s_we   = mem_we;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (req_ready) busy_rdy = 1'b1;
        chk({tag, " resp_vld"}, 32'(resp_valid), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(e_lat));
        chk({tag, " busy_rdy"}, 32'(busy_rdy), 32'd0);
        chk({tag, " memreq_cyc"}, 32'(req_cyc), e_mem ? 32'(e_lat) : 32'd0);
        chk({tag, " fault"}, 32'(resp_fault), 32'(e_flt));
        chk({tag, " rdata"}, resp_rdata, e_rd);
        chk({tag, " mem_addr"}, s_madr, e_madr);
        chk({tag, " mem_we"}, 32'(s_we), 32'(wr & e_mem));
        chk({tag, " wstrb"}, 32'(s_strb), 32'(e_strb));
        chk({tag, " wdata"}, s_wd, e_wd);
        @(posedge clk);
        #1;
        chk({tag, " pulse"}, 32'(resp_valid), 32'd0);
        chk({tag, " idle"}, 32'(req_ready), 32'd1);
        chk({tag, " rd_hold"}, resp_rdata, e_rd);
        chk({tag, " flt_hold"}, 32'(resp_fault), 32'(e_flt));
    endtask

    initial begin
        logic bad;
        // Reset values
        #3;
        chk("rst ready", 32'(req_ready), 32'd1);
        chk("rst resp_vld", 32'(resp_valid), 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst fault", 32'(resp_fault), 32'd0);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Zero-wait loads
        run_req("lb_a1",  1'b0, F3_B,  32'ha1, 32'h0, 0, 2'd0, 32'h0000_0022, 1, 32'ha0, 4'b0000, 32'h0);
        run_req("lb_ab",  1'b0, F3_B,  32'hab, 32'h0, 0, 2'd0, 32'hffff_ffc7, 1, 32'ha8, 4'b0000, 32'h0);
        run_req("lbu_ab", 1'b0, F3_BU, 32'hab, 32'h0, 0, 2'd0, 32'h0000_00c7, 1, 32'ha8, 4'b0000, 32'h0);
        run_req("lh_a8",  1'b0, F3_H,  32'ha8, 32'h0, 0, 2'd0, 32'hffff_e5f4, 1, 32'ha8, 4'b0000, 32'h0);
        run_req("lhu_aa", 1'b0, F3_HU, 32'haa, 32'h0, 0, 2'd0, 32'h0000_c7d6, 1, 32'ha8, 4'b0000, 32'h0);
        run_req("lw_a8",  1'b0, F3_W,  32'ha8, 32'h0, 0, 2'd0, 32'hc7d6_e5f4, 1, 32'ha8, 4'b0000, 32'h0);

        // Stores
        run_req("sb_b2", 1'b1, F3_B, 32'hb2, 32'h1234_5678, 0, 2'd0, 32'h0, 1, 32'hb0, 4'b0100, 32'h0078_0000);
        run_req("sh_b2", 1'b1, F3_H, 32'hb2, 32'h1234_5678, 0, 2'd0, 32'h0, 1, 32'hb0, 4'b1100, 32'h5678_0000);
        run_req("sw_b0", 1'b1, F3_W, 32'hb0, 32'h1234_5678, 0, 2'd0, 32'h0, 1, 32'hb0, 4'b1111, 32'h1234_5678);

        // Faults never reach memory and respond in the next cycle
        run_req("lh_a1_mis",  1'b0, F3_H,   32'ha1, 32'h0, 0, 2'd1, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
        run_req("sw_b2_mis",  1'b1, F3_W,   32'hb2, 32'h1234_5678, 0, 2'd1, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
        run_req("ld011_ill",  1'b0, 3'b011, 32'ha0, 32'h0, 0, 2'd2, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
        run_req("st100_ill",  1'b1, F3_BU,  32'hb0, 32'h1234_5678, 0, 2'd2, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
        run_req("ld111_prio", 1'b0, 3'b111, 32'ha1, 32'h0, 0, 2'd2, 32'h0, 0, 32'h0, 4'b0000, 32'h0);

        // Wait states, ack on the expiry cycle, and a real timeout
        run_req("lw_dly5",  1'b0, F3_W,  32'ha0, 32'h0, 5,  2'd0, 32'h4433_2211, 6,  32'ha0, 4'b0000, 32'h0);
        run_req("lhu_dly15", 1'b0, F3_HU, 32'ha0, 32'h0, 15, 2'd0, 32'h0000_2211, 16, 32'ha0, 4'b0000, 32'h0);
        run_req("lw_tmo",   1'b0, F3_W,  32'ha8, 32'h0, -1, 2'd3, 32'h0, 16, 32'ha8, 4'b0000, 32'h0);
        run_req("lb_after", 1'b0, F3_B,  32'ha1, 32'h0, 0,  2'd0, 32'h0000_0022, 1, 32'ha0, 4'b0000, 32'h0);

        // Reset in the middle of an access, then a stray ack
        @(negedge clk);
        ack_delay  = -1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'ha8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("mid memreq_on", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid memreq_off", 32'(mem_req), 32'd0);
        chk("mid ready", 32'(req_ready), 32'd1);
        chk("mid rdata", resp_rdata, 32'd0);
        chk("mid fault", 32'(resp_fault), 32'd0);
        chk("mid mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        stray_ack = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (resp_valid || mem_req || !req_ready || resp_rdata != 32'd0) bad = 1'b1;
        end
        chk("stray ignored", 32'(bad), 32'd0);
        stray_ack = 1'b0;
        run_req("lbu_post", 1'b0, F3_BU, 32'hab, 32'h0, 0, 2'd0, 32'h0000_00c7, 1, 32'ha8, 4'b0000, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
